// File: rtl/tdc_link_pkg.sv
// Shared definitions for the 32-slice TDC serial readout link.
package tdc_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SHIFT
  } state_e;

  localparam int TDC_SLICES = 32;

  // The transmitter updates sdi on the falling edge after ld, so the MSB is
  // stable for the first rising edge following the ld edge.
  localparam int DEFAULT_LD_LAT = 1;

endpackage

// File: rtl/sipo_shreg.sv
// MSB-first serial-in shift register with a bit counter; done flags the LSB sample.
module sipo_shreg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             sdi,
  output logic [WIDTH-1:0] word,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  // Only WIDTH-1 bits are stored; the final bit comes straight from sdi.
  logic [WIDTH-2:0] shreg;
  logic [CW-1:0]    bit_cnt;

  assign word = {shreg, sdi};
  assign done = shift_en && (bit_cnt == CW'(WIDTH - 1));

  // NOTE: the shift register is a plain register bank, not a RAM, so it can
  // take the reset; that keeps partial frames from leaking across a reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      shreg   <= word[WIDTH-2:0];
      bit_cnt <= done ? '0 : bit_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shiftin32_rx.sv
// Serial-to-parallel receiver for the TDC readout link: frame FSM,
// valid/ack output handshake, sticky link-error flags and frame counter.
module shiftin32_rx
  import tdc_link_pkg::*;
#(
  parameter int WIDTH  = TDC_SLICES,
  parameter int LD_LAT = DEFAULT_LD_LAT,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic             sdi,
  input  logic             clr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ack,
  output logic             overrun,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [2:0] LAT_INIT    = 3'(LD_LAT - 1);
  localparam state_e     START_STATE = (LD_LAT == 1) ? SHIFT : WAIT;

  state_e           state, state_d;
  logic [2:0]       lat_cnt, lat_d;
  logic             err_evt;
  logic             sr_clear;
  logic             sr_done;
  logic [WIDTH-1:0] sr_word;
  logic             accept;

  // Any ld that is not the frame's own LSB edge restarts the shifter.
  assign sr_clear = ld && !sr_done;
  assign accept   = sr_done && (!data_valid || data_ack);

  sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (sr_clear),
    .shift_en (state == SHIFT),
    .sdi      (sdi),
    .word     (sr_word),
    .done     (sr_done)
  );

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_d = state;
    lat_d   = lat_cnt;
    err_evt = 1'b0;
    case (state)
      IDLE: begin
        if (ld) begin
          state_d = START_STATE;
          lat_d   = LAT_INIT;
        end
      end
      WAIT: begin
        if (ld) begin
          err_evt = 1'b1;
          state_d = START_STATE;
          lat_d   = LAT_INIT;
        end else begin
          lat_d = lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ld) begin
          // ld on the LSB edge chains the next frame without an error.
          err_evt = !sr_done;
          state_d = START_STATE;
          lat_d   = LAT_INIT;
        end else if (sr_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_d;
      lat_cnt <= lat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (accept) begin
        data_out   <= sr_word;
        data_valid <= 1'b1;
      end else if (data_ack) begin
        data_valid <= 1'b0;
      end

      // Error events take precedence over a simultaneous clr.
      if (sr_done && !accept) overrun <= 1'b1;
      else if (clr)           overrun <= 1'b0;

      if (err_evt)  frame_err <= 1'b1;
      else if (clr) frame_err <= 1'b0;

      if (sr_done) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_shiftin32_rx.sv
// Directed bench for shiftin32_rx: default build plus an LD_LAT=3 / CNT_W=4 build.
module tb_shiftin32_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld = 1'b0, sdi = 1'b0, clr = 1'b0, data_ack = 1'b0;
  logic [31:0] data_out;
  logic        data_valid, overrun, frame_err;
  logic [15:0] frame_cnt;

  logic        b_ld = 1'b0, b_sdi = 1'b0, b_clr = 1'b0, b_ack = 1'b0;
  logic [31:0] b_data_out;
  logic        b_data_valid, b_overrun, b_frame_err;
  logic [3:0]  b_frame_cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  shiftin32_rx dut (
    .clk(clk), .rst_n(rst_n), .ld(ld), .sdi(sdi), .clr(clr),
    .data_out(data_out), .data_valid(data_valid), .data_ack(data_ack),
    .overrun(overrun), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  shiftin32_rx #(.LD_LAT(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ld(b_ld), .sdi(b_sdi), .clr(b_clr),
    .data_out(b_data_out), .data_valid(b_data_valid), .data_ack(b_ack),
    .overrun(b_overrun), .frame_err(b_frame_err), .frame_cnt(b_frame_cnt)
  );

  // Inputs change on the falling edge; outputs are observed 1 time unit after the rising edge.
  task automatic cyc(input logic l, input logic s, input logic a, input logic c);
    @(negedge clk);
    ld = l; sdi = s; data_ack = a; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic cycb(input logic l, input logic s, input logic a);
    @(negedge clk);
    b_ld = l; b_sdi = s; b_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] w, input logic ack_last, input logic clr_last);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 31; i >= 1; i--) cyc(1'b0, w[i], 1'b0, 1'b0);
    cyc(1'b0, w[0], ack_last, clr_last);
  endtask

  task automatic send_b(input logic [31:0] w, input logic a);
    cycb(1'b1, 1'b0, a);
    cycb(1'b0, 1'b1, a);
    cycb(1'b0, 1'b1, a);
    for (int i = 31; i >= 0; i--) cycb(1'b0, w[i], a);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (data_out !== 32'h0) $display("FAIL reset_data got %h exp 0", data_out); else n_pass++;
    n_total++; if (data_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", data_valid); else n_pass++;
    n_total++; if (overrun !== 1'b0 || frame_err !== 1'b0) $display("FAIL reset_flags got %b%b exp 00", overrun, frame_err); else n_pass++;
    n_total++; if (frame_cnt !== 16'd0) $display("FAIL reset_cnt got %0d exp 0", frame_cnt); else n_pass++;
    n_total++; if (b_frame_cnt !== 4'd0 || b_data_valid !== 1'b0) $display("FAIL reset_b got cnt %0d valid %b exp 0 0", b_frame_cnt, b_data_valid); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    send_frame(32'hA5C3_0F81, 1'b0, 1'b0);
    n_total++; if (data_out !== 32'hA5C3_0F81) $display("FAIL single_data got %h exp a5c30f81", data_out); else n_pass++;
    n_total++; if (data_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", data_valid); else n_pass++;
    n_total++; if (frame_cnt !== 16'd1) $display("FAIL single_cnt got %0d exp 1", frame_cnt); else n_pass++;
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    n_total++; if (data_valid !== 1'b1 || data_out !== 32'hA5C3_0F81) $display("FAIL single_hold got %b %h exp 1 a5c30f81", data_valid, data_out); else n_pass++;
    // Ack on the LSB edge lets the new word replace the held one.
    send_frame(32'h0F0F_1234, 1'b1, 1'b0);
    n_total++; if (data_out !== 32'h0F0F_1234) $display("FAIL ack_lsb_data got %h exp 0f0f1234", data_out); else n_pass++;
    n_total++; if (data_valid !== 1'b1 || overrun !== 1'b0) $display("FAIL ack_lsb_flags got valid %b ovr %b exp 1 0", data_valid, overrun); else n_pass++;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    n_total++; if (data_valid !== 1'b0) $display("FAIL ack_clear got %b exp 0", data_valid); else n_pass++;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    n_total++; if (data_valid !== 1'b0 || data_out !== 32'h0F0F_1234) $display("FAIL ack_idle got %b %h exp 0 0f0f1234", data_valid, data_out); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1, w2;
    w1 = 32'h0000_0001;
    w2 = 32'h8000_0000;
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 31; i >= 1; i--) cyc(1'b0, w1[i], 1'b0, 1'b0);
    cyc(1'b1, w1[0], 1'b0, 1'b0);
    n_total++; if (data_out !== 32'h0000_0001 || data_valid !== 1'b1) $display("FAIL b2b_first got %h %b exp 00000001 1", data_out, data_valid); else n_pass++;
    for (int i = 31; i >= 0; i--) begin
      cyc(1'b0, w2[i], (i == 31), 1'b0);
      if (i == 31) begin
        n_total++; if (data_valid !== 1'b0) $display("FAIL b2b_ack got %b exp 0", data_valid); else n_pass++;
      end
    end
    n_total++; if (data_out !== 32'h8000_0000 || data_valid !== 1'b1) $display("FAIL b2b_second got %h %b exp 80000000 1", data_out, data_valid); else n_pass++;
    n_total++; if (frame_err !== 1'b0 || overrun !== 1'b0) $display("FAIL b2b_flags got err %b ovr %b exp 0 0", frame_err, overrun); else n_pass++;
    n_total++; if (frame_cnt !== 16'd2) $display("FAIL b2b_cnt got %0d exp 2", frame_cnt); else n_pass++;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    do_reset();
    send_frame(32'h1357_9BDF, 1'b0, 1'b0);
    send_frame(32'hFFFF_0000, 1'b0, 1'b0);
    n_total++; if (data_out !== 32'h1357_9BDF) $display("FAIL ovr_data got %h exp 13579bdf", data_out); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL ovr_flag got %b exp 1", overrun); else n_pass++;
    n_total++; if (frame_cnt !== 16'd2) $display("FAIL ovr_cnt got %0d exp 2", frame_cnt); else n_pass++;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_total++; if (overrun !== 1'b0) $display("FAIL ovr_clr got %b exp 0", overrun); else n_pass++;
    // A drop on the same edge as clr keeps the flag set.
    send_frame(32'h2468_ACE0, 1'b0, 1'b1);
    n_total++; if (overrun !== 1'b1 || data_out !== 32'h1357_9BDF) $display("FAIL ovr_set_wins got %b %h exp 1 13579bdf", overrun, data_out); else n_pass++;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_abort();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(32'hDEAD_BEEF, 1'b0, 1'b0);
    n_total++; if (frame_err !== 1'b1) $display("FAIL abort_err got %b exp 1", frame_err); else n_pass++;
    n_total++; if (data_out !== 32'hDEAD_BEEF) $display("FAIL abort_data got %h exp deadbeef", data_out); else n_pass++;
    n_total++; if (frame_cnt !== 16'd1) $display("FAIL abort_cnt got %0d exp 1", frame_cnt); else n_pass++;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    n_total++; if (frame_err !== 1'b0) $display("FAIL abort_clr got %b exp 0", frame_err); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] w;
    w = 32'hFFFF_FFFF;
    do_reset();
    send_frame(32'h7777_7777, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 31; i > 11; i--) cyc(1'b0, w[i], 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, w[11], 1'b0, 1'b0);
    rst_n = 1'b1;
    n_total++; if (data_out !== 32'h0 || data_valid !== 1'b0) $display("FAIL midrst_out got %h %b exp 0 0", data_out, data_valid); else n_pass++;
    n_total++; if (overrun !== 1'b0 || frame_err !== 1'b0 || frame_cnt !== 16'd0) $display("FAIL midrst_flags got %b %b %0d exp 0 0 0", overrun, frame_err, frame_cnt); else n_pass++;
    for (int i = 10; i >= 0; i--) cyc(1'b0, w[i], 1'b0, 1'b0);
    n_total++; if (data_valid !== 1'b0 || frame_cnt !== 16'd0) $display("FAIL midrst_tail got %b %0d exp 0 0", data_valid, frame_cnt); else n_pass++;
    send_frame(32'h3C3C_A5A5, 1'b0, 1'b0);
    n_total++; if (data_out !== 32'h3C3C_A5A5 || frame_cnt !== 16'd1) $display("FAIL midrst_next got %h %0d exp 3c3ca5a5 1", data_out, frame_cnt); else n_pass++;
  endtask

  task automatic test_lat3_wrap();
    logic [31:0] w;
    send_b(32'h1234_5678, 1'b0);
    n_total++; if (b_data_out !== 32'h1234_5678 || b_data_valid !== 1'b1) $display("FAIL lat3_data got %h %b exp 12345678 1", b_data_out, b_data_valid); else n_pass++;
    n_total++; if (b_frame_cnt !== 4'd1 || b_frame_err !== 1'b0) $display("FAIL lat3_cnt got %0d %b exp 1 0", b_frame_cnt, b_frame_err); else n_pass++;
    for (int f = 2; f <= 16; f++) begin
      w = {8{4'(f)}};
      send_b(w, 1'b1);
      if (f == 15) begin
        n_total++; if (b_frame_cnt !== 4'hF) $display("FAIL wrap_max got %0d exp 15", b_frame_cnt); else n_pass++;
      end
    end
    n_total++; if (b_frame_cnt !== 4'd0) $display("FAIL wrap_zero got %0d exp 0", b_frame_cnt); else n_pass++;
    n_total++; if (b_data_out !== 32'h0000_0000 || b_overrun !== 1'b0) $display("FAIL wrap_last got %h %b exp 00000000 0", b_data_out, b_overrun); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_reset_mid_frame();
    test_lat3_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shiftin32_rx.md
Name: shiftin32_rx

Overview:
- Serial-to-parallel receiver for the 32-slice TDC readout link.
- Accepts the MSB-first serial stream and its frame-load strobe, both driven by the 32-bit shift-out transmitter, and rebuilds each 32-bit time-slice word.
- Presents each word on a valid/ack handshake to the readout FIFO/DAQ logic.
- Keeps error flags and a frame counter for link diagnostics.

Parameters:
- WIDTH, 32, bits per frame; bit WIDTH-1 arrives first.
- LD_LAT, 1, rising edges from the edge that samples ld high to the edge that samples the MSB; legal range 1..4.
- CNT_W, 16, width of the received-frame counter.

Ports:
- clk  in  1  link clock; all sampling and state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- ld  in  1  frame-load strobe from the transmitter; one cycle high per frame.
- sdi  in  1  serial data from the transmitter (RDa).
- clr  in  1  synchronous clear of sticky error flags.
- data_out  out  WIDTH  last accepted frame; bit WIDTH-1 is the first serial bit.
- data_valid  out  1  data_out holds an unconsumed word.
- data_ack  in  1  consumer accepts data_out; effective only when data_valid=1.
- overrun  out  1  sticky; a frame completed while data_valid=1 and no ack arrived that cycle.
- frame_err  out  1  sticky; ld seen while a frame was in progress (WAIT or SHIFT).
- frame_cnt  out  CNT_W  count of frames completed, including dropped ones; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE; shift register and bit counter are cleared.
  - Outputs: data_out=0, data_valid=0, overrun=0, frame_err=0, frame_cnt=0.
  - Reset overrides every other input in the same cycle, including mid-frame. A partial frame is discarded and is not counted.
- State machine:
  - IDLE: on ld=1, load lat_cnt=LD_LAT-1. Go to SHIFT if LD_LAT=1, else go to WAIT.
  - WAIT: decrement lat_cnt each cycle. Go to SHIFT when lat_cnt reaches 0.
  - SHIFT: each cycle, shreg <= {shreg[WIDTH-2:0], sdi} and bit_cnt increments. After WIDTH samples (bit_cnt = WIDTH-1 on that edge), perform frame completion and return to IDLE.
- Frame timing: with ld sampled at edge k, the MSB is sampled at edge k+LD_LAT and the LSB at edge k+LD_LAT+WIDTH-1.
- Frame completion: the full word is {shreg[WIDTH-2:0], sdi} at the LSB edge, and frame_cnt increments on that same edge.
  - If data_valid=0, or data_ack=1 in that cycle: data_out <= word and data_valid <= 1, visible the cycle after the LSB edge. Total latency from the LSB edge to data_valid is 1 cycle.
  - Otherwise: the word is dropped, data_out is unchanged, and overrun <= 1.
- Handshake:
  - data_valid clears on the edge where data_ack=1, unless a new word is written on that same edge; in that case data_valid stays 1.
  - data_ack while data_valid=0 is ignored.
- ld while in WAIT or SHIFT:
  - frame_err <= 1.
  - The partial frame is discarded and not counted.
  - Reception restarts as if coming from IDLE: lat_cnt reloads and the shift register and bit counter clear.
- ld on the same edge as the LSB sample:
  - The frame completes normally.
  - The new ld starts the next frame.
  - frame_err is not set.
- clr: clears overrun and frame_err on the next edge. If an error event occurs in the same cycle, the set wins.
- frame_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- sdi is ignored outside SHIFT.

Decomposition:
- Shared package (tdc_link_pkg):
  - state enum {IDLE, WAIT, SHIFT}.
  - Constant TDC_SLICES=32.
  - Default LD_LAT, matched to the transmitter's negedge-latch output timing.
- One natural sub-module: sipo_shreg (parameterised WIDTH shift register with bit counter and done pulse). FSM, handshake and flags stay in the top module.

Test Plan:
- Single frame: ld pulse, then serialise 32'hA5C3_0F81 MSB-first with LD_LAT=1 -> one cycle after the LSB edge, data_out=32'hA5C3_0F81, data_valid=1, frame_cnt=1; with data_ack held low, data_valid stays 1.
- Back-to-back frames: 32'h0000_0001 then 32'h8000_0000, with ld on the LSB edge of the first and data_ack pulsed each time -> both words delivered in order, frame_err=0, frame_cnt=2.
- Overrun: two frames with data_ack=0 throughout -> data_out keeps the first word, overrun=1, frame_cnt=2; clr -> overrun=0 next cycle.
- Aborted frame: ld re-asserted after 10 bits, then full frame 32'hDEAD_BEEF -> frame_err=1, data_out=32'hDEAD_BEEF, frame_cnt=1.
- Reset mid-frame: rst_n=0 for one edge at bit 20 -> all outputs 0, no word delivered; the next full frame is received correctly.
- LD_LAT=3 build plus counter wrap with CNT_W=4: frame 32'h1234_5678 with MSB at edge k+3 -> correct word; 16 frames -> frame_cnt returns to 0.
